ma_lsu: RTL

Load/store unit between the MA pipeline stage and the data memory. It accepts one memory operation per request: size code, address, store data and a signed/unsigned flag. It issues a word-aligned, byte-enabled access on a valid/ack memory port and returns extracted, sign/zero-extended load data or store completion. While busy it holds the pipeline through `req_ready`, and it flags misaligned or malformed operations without touching memory.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/ma_lsu.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MA-stage load/store unit.
// Size codes, FSM states and lane helpers.
package lsu_pkg;

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_B    = 2'b01;
   localparam logic [1:0] SZ_H    = 2'b10;
   localparam logic [1:0] SZ_W    = 2'b11;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_ACCESS,
      LSU_RESP
   } lsu_state_e;

   function automatic logic [3:0] lsu_be(
      input logic [1:0] size,
      input logic [1:0] off
   );
      case (size)
         SZ_B:    return 4'b0001 << off;
         SZ_H:    return 4'b0011 << off;
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // A request naming both a load and a store is malformed.
   function automatic logic lsu_misaligned(
      input logic [1:0] rd,
      input logic [1:0] wr,
      input logic [1:0] off
   );
      logic [1:0] size;
      size = rd | wr;
      if (rd != SZ_NONE && wr != SZ_NONE)
         return 1'b1;
      case (size)
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] lsu_lanes(
      input logic [1:0]  size,
      input logic [31:0] wdata
   );
      case (size)
         SZ_B:    return {4{wdata[7:0]}};
         SZ_H:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shift the read word down to the
// addressed lane, then sign- or zero-extend it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] data
);

   logic [31:0] sh;

   assign sh = rdata >> {off, 3'b000};

   always_comb begin
      data = '0;
      case (size)
         SZ_B:    data = {{24{~uns & sh[7]}}, sh[7:0]};
         SZ_H:    data = {{16{~uns & sh[15]}}, sh[15:0]};
         SZ_W:    data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/ma_lsu.sv
// Load/store unit between the MA stage and data memory:
// one op at a time over a valid/ack word-aligned port.
module ma_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  mem_read,
   input  logic [1:0]  mem_write,
   input  logic        load_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int CW =
      (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   lsu_state_e state, nxt;

   logic          go, bad, timeout;
   logic [1:0]    size;
   logic [CW-1:0] cnt;
   logic [1:0]    off_q, rd_q;
   logic          uns_q, misal_q, berr_q;
   logic [31:0]   rdata_q, ld_data;

   assign size = mem_read | mem_write;
   assign go   = req_valid && size != SZ_NONE;
   assign bad  = lsu_misaligned(mem_read, mem_write,
                                addr[1:0]);

   // Ack wins over timeout in the final allowed cycle.
   assign timeout = (ACK_TIMEOUT != 0) && !mem_ack &&
                    (cnt == CW'(ACK_TIMEOUT - 1));

   lsu_load_align u_align (
      .rdata (mem_rdata),
      .off   (off_q),
      .size  (rd_q),
      .uns   (uns_q),
      .data  (ld_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= LSU_IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         LSU_IDLE:
            if (go)
               nxt = bad ? LSU_RESP : LSU_ACCESS;
         LSU_ACCESS:
            if (mem_ack || timeout)
               nxt = LSU_RESP;
         LSU_RESP:
            nxt = LSU_IDLE;
         default:
            nxt = LSU_IDLE;
      endcase
   end

   always_comb begin
      req_ready = state == LSU_IDLE;
      mem_req   = state == LSU_ACCESS;
      rsp_valid = state == LSU_RESP;
      rsp_rdata = rsp_valid ? rdata_q : '0;
      misalign  = rsp_valid & misal_q;
      bus_err   = rsp_valid & berr_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         off_q     <= '0;
         rd_q      <= SZ_NONE;
         uns_q     <= 1'b0;
         misal_q   <= 1'b0;
         berr_q    <= 1'b0;
         rdata_q   <= '0;
         cnt       <= '0;
      end else begin
         if (state == LSU_IDLE && go) begin
            misal_q <= bad;
            berr_q  <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
            if (!bad) begin
               mem_we    <= mem_write != SZ_NONE;
               mem_addr  <= {addr[31:2], 2'b00};
               mem_be    <= lsu_be(size, addr[1:0]);
               mem_wdata <= lsu_lanes(size, wdata);
               off_q     <= addr[1:0];
               rd_q      <= mem_read;
               uns_q     <= load_unsigned;
            end
         end
         if (state == LSU_ACCESS) begin
            if (mem_ack)
               rdata_q <= ld_data;
            else if (timeout)
               berr_q <= 1'b1;
            else
               cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
